ctr_rr_arbiter: RTL

Round-robin controller that shares one WIDTH-bit cycle counter between NREQ requesters in the demo user design. Each requester asks for the counter, is granted exclusive use, and has it cleared on grant and incremented while it holds the grant. On release, the accumulated count is published as a one-cycle result tagged with the requester ID. A hold-time limit stops any single requester from monopolising the counter.

---
 rtl/ctr_arb_pkg.sv | 41 ++++
 rtl/ctr_core.sv | 28 ++
 rtl/ctr_rr_arbiter.sv | 128 ++++++++++++
 3 files changed

// File: rtl/ctr_arb_pkg.sv
// Shared types and the round-robin pick helper for the counter arbiter.
package ctr_arb_pkg;

   localparam int MAX_NREQ = 8;
   localparam int MAX_ID_W = 3;

   typedef enum logic [1:0] {
      IDLE,
      GRANT,
      RUN,
      RELEASE
   } arb_state_t;

   typedef struct packed {
      logic                found;
      logic [MAX_ID_W-1:0] idx;
   } pick_t;

   // First set bit at or after ptr, wrapping at nreq; lowest offset wins.
   function automatic pick_t rr_pick(
      input logic [MAX_NREQ-1:0] req,
      input logic [MAX_ID_W-1:0] ptr,
      input int unsigned         nreq
   );
      pick_t p;
      int    j;
      p = '0;
      for (int i = MAX_NREQ - 1; i >= 0; i--) begin
         j = int'(ptr) + i;
         if (j >= int'(nreq)) j = j - int'(nreq);
         if (i < int'(nreq) && j < int'(nreq)) begin
            if (req[j[MAX_ID_W-1:0]]) begin
               p.found = 1'b1;
               p.idx   = j[MAX_ID_W-1:0];
            end
         end
      end
      return p;
   endfunction

endpackage

// File: rtl/ctr_core.sv
// Shared saturating cycle counter: cleared on clr, counts on en up to MAX_HOLD.
module ctr_core
   import ctr_arb_pkg::*;
#(
   parameter int WIDTH    = 16,
   parameter int MAX_HOLD = 255
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   output logic             sat_out,
   output logic [WIDTH-1:0] ctr
);

   localparam logic [WIDTH-1:0] LIMIT = WIDTH'(MAX_HOLD);

   assign sat_out = (ctr == LIMIT);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         ctr <= '0;
      end else if (en && !sat_out) begin
         ctr <= ctr + WIDTH'(1);
      end
   end

endmodule

// File: rtl/ctr_rr_arbiter.sv
// Round-robin owner of one shared cycle counter; publishes the hold count
// tagged with the requester ID on every release.
module ctr_rr_arbiter
   import ctr_arb_pkg::*;
#(
   parameter int WIDTH    = 16,
   parameter int NREQ     = 4,
   parameter int MAX_HOLD = 255,
   parameter int ID_W     = $clog2(NREQ)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [NREQ-1:0]  req,
   output logic [NREQ-1:0]  gnt,
   output logic             busy,
   output logic [WIDTH-1:0] ctr_val,
   output logic             res_valid,
   output logic [ID_W-1:0]  res_id,
   output logic [WIDTH-1:0] res_data,
   output logic             res_timeout
);

   arb_state_t      state;
   arb_state_t      state_nxt;
   logic [ID_W-1:0] owner;
   logic [ID_W-1:0] owner_nxt;
   logic [ID_W-1:0] ptr;
   logic [ID_W-1:0] ptr_nxt;
   logic [ID_W-1:0] win;
   logic [NREQ-1:0] gnt_nxt;
   pick_t           pick;
   logic            own_req;
   logic            clr;
   logic            en;
   logic            sat;
   logic [WIDTH-1:0] ctr;

   ctr_core #(
      .WIDTH    (WIDTH),
      .MAX_HOLD (MAX_HOLD)
   ) u_core (
      .clk     (clk),
      .rst     (rst),
      .clr     (clr),
      .en      (en),
      .sat_out (sat),
      .ctr     (ctr)
   );

   assign ctr_val = ctr;
   assign busy    = (state != IDLE);
   assign own_req = req[owner];

   always_comb begin
      pick = rr_pick(MAX_NREQ'(req), MAX_ID_W'(ptr), NREQ);
      win  = pick.idx[ID_W-1:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         owner <= '0;
         ptr   <= '0;
      end else begin
         state <= state_nxt;
         owner <= owner_nxt;
         ptr   <= ptr_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      owner_nxt = owner;
      ptr_nxt   = ptr;
      clr       = 1'b0;
      en        = 1'b0;
      unique case (state)
         IDLE: begin
            if (pick.found) begin
               state_nxt = GRANT;
               owner_nxt = win;
               ptr_nxt   = (win == ID_W'(NREQ - 1)) ? '0 : win + ID_W'(1);
            end
         end
         GRANT: begin
            clr       = 1'b1;
            state_nxt = own_req ? RUN : RELEASE;
         end
         RUN: begin
            en = own_req && !sat;
            if (!own_req || sat) state_nxt = RELEASE;
         end
         RELEASE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_comb begin
      gnt_nxt = '0;
      if (state_nxt == GRANT || state_nxt == RUN) begin
         gnt_nxt[owner_nxt] = 1'b1;
      end
   end

   // A release straight from GRANT reports zero: the clear lands on that edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         gnt         <= '0;
         res_valid   <= 1'b0;
         res_id      <= '0;
         res_data    <= '0;
         res_timeout <= 1'b0;
      end else begin
         gnt         <= gnt_nxt;
         res_valid   <= (state_nxt == RELEASE);
         res_timeout <= (state == RUN) && (state_nxt == RELEASE) && sat;
         if (state_nxt == RELEASE) begin
            res_id   <= owner;
            res_data <= (state == GRANT) ? '0 : ctr;
         end
      end
   end

endmodule
